// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the two-road traffic light interface: decodes the light pair,
// checks code, order and dwell, reports violations. Optional err_count via TRAFFIC_MON_ERR_COUNT_EN.
//
// state  | meaning
// SYNC   | not locked; waiting for a fresh NS green sample
// NS_G   | north-south green
// NS_Y   | north-south yellow
// AR1    | all red after NS yellow
// EW_G   | east-west green
// EW_Y   | east-west yellow
// AR2    | all red after EW yellow; next NS_G completes a cycle
module traffic_light_monitor #(
   parameter int GREEN_CYCLES  = 5,
   parameter int YELLOW_CYCLES = 1,
   parameter int ALLRED_CYCLES = 1,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [2:0]       ns_light,
   input  logic [2:0]       ew_light,
   input  logic             err_clr,
   output logic             synced,
   output logic [2:0]       phase,
   output logic             err_pulse,
   output logic [2:0]       err_code,
   output logic             err_sticky,
   output logic [CNT_W-1:0] cycle_count
`ifdef TRAFFIC_MON_ERR_COUNT_EN
   ,
   output logic [CNT_W-1:0] err_count
`endif
);

   localparam int MAX_GY  = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
   localparam int MAX_REQ = (MAX_GY > ALLRED_CYCLES) ? MAX_GY : ALLRED_CYCLES;
   localparam int DW_W    = $clog2(MAX_REQ + 2);

   localparam logic [DW_W-1:0] GREEN_REQ  = DW_W'(GREEN_CYCLES);
   localparam logic [DW_W-1:0] YELLOW_REQ = DW_W'(YELLOW_CYCLES);
   localparam logic [DW_W-1:0] ALLRED_REQ = DW_W'(ALLRED_CYCLES);

   typedef enum logic [2:0] {
      P_SYNC = 3'd0, P_NS_G = 3'd1, P_NS_Y = 3'd2, P_AR1 = 3'd3,
      P_EW_G = 3'd4, P_EW_Y = 3'd5, P_AR2 = 3'd6
   } phase_t;

   localparam logic [2:0] E_NONE = 3'd0, E_ILLEGAL = 3'd1, E_BAD_SEQ = 3'd2,
                          E_SHORT = 3'd3, E_LONG = 3'd4;

   phase_t           phase_q, phase_d, dec_phase, nxt_phase;
   logic [DW_W-1:0]  dwell_q, dwell_d, req_dwell;
   logic             first_q, first_d;
   logic             dec_ill, viol, cyc_inc;
   logic [2:0]       viol_code;
   logic             err_pulse_q, err_sticky_q;
   logic [2:0]       err_code_q;
   logic [CNT_W-1:0] cycle_count_q;

   // Decode; all-red is resolved against the current phase so it lands on AR1 or AR2.
   always_comb begin
      dec_ill   = 1'b0;
      dec_phase = P_SYNC;
      case ({ns_light, ew_light})
         6'b010_100: dec_phase = P_NS_G;
         6'b001_100: dec_phase = P_NS_Y;
         6'b100_010: dec_phase = P_EW_G;
         6'b100_001: dec_phase = P_EW_Y;
         6'b100_100: begin
            if (phase_q == P_NS_Y || phase_q == P_AR1)      dec_phase = P_AR1;
            else if (phase_q == P_EW_Y || phase_q == P_AR2) dec_phase = P_AR2;
            else                                            dec_phase = P_SYNC;
         end
         default: dec_ill = 1'b1;
      endcase
   end

   always_comb begin
      nxt_phase = P_SYNC;
      req_dwell = GREEN_REQ;
      case (phase_q)
         P_NS_G: begin nxt_phase = P_NS_Y; req_dwell = GREEN_REQ;  end
         P_NS_Y: begin nxt_phase = P_AR1;  req_dwell = YELLOW_REQ; end
         P_AR1:  begin nxt_phase = P_EW_G; req_dwell = ALLRED_REQ; end
         P_EW_G: begin nxt_phase = P_EW_Y; req_dwell = GREEN_REQ;  end
         P_EW_Y: begin nxt_phase = P_AR2;  req_dwell = YELLOW_REQ; end
         P_AR2:  begin nxt_phase = P_NS_G; req_dwell = ALLRED_REQ; end
         default: begin nxt_phase = P_SYNC; req_dwell = GREEN_REQ; end
      endcase
   end

   // Next-state logic and violation detection, checks in priority order.
   always_comb begin
      phase_d   = phase_q;
      dwell_d   = dwell_q;
      first_d   = first_q;
      viol      = 1'b0;
      viol_code = E_NONE;
      cyc_inc   = 1'b0;
      if (phase_q == P_SYNC) begin
         if (!dec_ill && dec_phase == P_NS_G) begin
            phase_d = P_NS_G;
            dwell_d = DW_W'(1);
            first_d = 1'b1;
         end
      end else begin
         if (dec_ill) begin
            viol = 1'b1; viol_code = E_ILLEGAL;
         end else if (dec_phase != phase_q && dec_phase != nxt_phase) begin
            viol = 1'b1; viol_code = E_BAD_SEQ;
         end else if (dec_phase == nxt_phase && dwell_q < req_dwell && !first_q) begin
            viol = 1'b1; viol_code = E_SHORT;
         end else if (dec_phase == phase_q && dwell_q >= req_dwell) begin
            viol = 1'b1; viol_code = E_LONG;
         end else if (dec_phase == nxt_phase) begin
            phase_d = nxt_phase;
            dwell_d = DW_W'(1);
            first_d = 1'b0;
            cyc_inc = (phase_q == P_AR2);
         end else if (dwell_q != {DW_W{1'b1}}) begin
            dwell_d = dwell_q + DW_W'(1);
         end
         if (viol) begin
            phase_d = P_SYNC;
            dwell_d = '0;
            first_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         phase_q       <= P_SYNC;
         dwell_q       <= '0;
         first_q       <= 1'b0;
         err_pulse_q   <= 1'b0;
         err_code_q    <= E_NONE;
         err_sticky_q  <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         phase_q     <= phase_d;
         dwell_q     <= dwell_d;
         first_q     <= first_d;
         err_pulse_q <= viol;
         if (viol) begin
            err_code_q   <= viol_code;
            err_sticky_q <= 1'b1;
         end else if (err_clr) begin
            err_code_q   <= E_NONE;
            err_sticky_q <= 1'b0;
         end
         if (cyc_inc) cycle_count_q <= cycle_count_q + CNT_W'(1);
      end
   end

`ifdef TRAFFIC_MON_ERR_COUNT_EN
   logic [CNT_W-1:0] err_count_q;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                              err_count_q <= '0;
      else if (viol && err_clr)               err_count_q <= CNT_W'(1);
      else if (viol && err_count_q != '1)     err_count_q <= err_count_q + CNT_W'(1);
      else if (err_clr && !viol)              err_count_q <= '0;
   end
   assign err_count = err_count_q;
`endif

   always_comb begin
      synced      = (phase_q != P_SYNC);
      phase       = phase_q;
      err_pulse   = err_pulse_q;
      err_code    = err_code_q;
      err_sticky  = err_sticky_q;
      cycle_count = cycle_count_q;
   end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor; define TRAFFIC_MON_ERR_COUNT_EN to also check err_count.
module tb_traffic_light_monitor;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [2:0] ns_light = 3'b100;
   logic [2:0] ew_light = 3'b100;
   logic       err_clr = 1'b0;
   logic       synced, err_pulse, err_sticky;
   logic [2:0] phase, err_code;
   logic [7:0] cycle_count;
`ifdef TRAFFIC_MON_ERR_COUNT_EN
   logic [7:0] err_count;
`endif

   int n_checks = 0;
   int n_errs   = 0;

   traffic_light_monitor dut (
      .clk(clk), .rstn(rstn), .ns_light(ns_light), .ew_light(ew_light), .err_clr(err_clr),
      .synced(synced), .phase(phase), .err_pulse(err_pulse), .err_code(err_code),
      .err_sticky(err_sticky), .cycle_count(cycle_count)
`ifdef TRAFFIC_MON_ERR_COUNT_EN
      , .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [2:0] R = 3'b100, G = 3'b010, Y = 3'b001;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one sample; outputs are observed 1 time unit after the capturing edge.
   task automatic step(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
      ns_light = ns;
      ew_light = ew;
      err_clr  = clr;
      @(posedge clk);
      #1;
      err_clr  = 1'b0;
   endtask

   // One legal 14-sample period: G5 Y1 R1 G5 Y1 R1, with hand-written expected phases.
   logic [2:0] ns_tab [14] = '{G,G,G,G,G,Y,R,R,R,R,R,R,R,R};
   logic [2:0] ew_tab [14] = '{R,R,R,R,R,R,R,G,G,G,G,G,Y,R};
   logic [2:0] ph_tab [14] = '{1,1,1,1,1,2,3,4,4,4,4,4,5,6};

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_synced", synced, 0);
      check("rst_phase", phase, 0);
      check("rst_pulse", err_pulse, 0);
      check("rst_code", err_code, 0);
      check("rst_sticky", err_sticky, 0);
      check("rst_cycles", cycle_count, 0);
      rstn = 1'b1;
      step(R, R, 0);
      check("sync_ignore_ar", phase, 0);

      // 1: three legal periods plus one NS green
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 14; i++) begin
            step(ns_tab[i], ew_tab[i], 0);
            check("t1_phase", phase, ph_tab[i]);
            check("t1_pulse", err_pulse, 0);
            check("t1_synced", synced, 1);
            if (i == 0) check("t1_cycles", cycle_count, p);
         end
      end
      step(G, R, 0);
      check("t1_final_phase", phase, 1);
      check("t1_final_cycles", cycle_count, 3);

      // 2: illegal code while synced
      step(G, G, 0);
      check("t2_pulse", err_pulse, 1);
      check("t2_code", err_code, 1);
      check("t2_sticky", err_sticky, 1);
      check("t2_phase", phase, 0);
      check("t2_synced", synced, 0);
      step(R, R, 0);
      check("t2_pulse_off", err_pulse, 0);
      check("t2_still_sync", phase, 0);

      // 3: NS green jumping straight to EW green
      repeat (5) step(G, R, 0);
      check("t3_pre_phase", phase, 1);
      step(R, G, 0);
      check("t3_code", err_code, 2);
      check("t3_pulse", err_pulse, 1);
      check("t3_phase", phase, 0);
      step(G, R, 0);
      check("t3_resync", synced, 1);
      check("t3_resync_phase", phase, 1);

      // 4a: green held for 6 samples
      for (int i = 2; i <= 5; i++) begin
         step(G, R, 0);
         check("t4_hold_pulse", err_pulse, 0);
      end
      step(G, R, 0);
      check("t4_long_code", err_code, 4);
      check("t4_long_pulse", err_pulse, 1);
      check("t4_long_phase", phase, 0);

      // 4b: EW green cut short to 3 samples
      for (int i = 0; i < 7; i++) step(ns_tab[i], ew_tab[i], 0);
      repeat (3) step(R, G, 0);
      check("t4_ewg_phase", phase, 4);
      step(R, Y, 0);
      check("t4_short_code", err_code, 3);
      check("t4_short_pulse", err_pulse, 1);

      // first green after sync is exempt from the short-dwell check
      repeat (2) step(G, R, 0);
      step(Y, R, 0);
      check("t4_first_short_ok", err_pulse, 0);
      check("t4_first_phase", phase, 2);

      // 5: err_clr coinciding with a violation, then alone
      step(3'b111, 3'b000, 1);
      check("t5_sticky_kept", err_sticky, 1);
      check("t5_code", err_code, 1);
      check("t5_pulse", err_pulse, 1);
`ifdef TRAFFIC_MON_ERR_COUNT_EN
      check("t5_cnt_clr_viol", err_count, 1);
`endif
      step(R, R, 1);
      check("t5_sticky_clr", err_sticky, 0);
      check("t5_code_clr", err_code, 0);
`ifdef TRAFFIC_MON_ERR_COUNT_EN
      check("t5_cnt_clr", err_count, 0);
`endif

      // 6: three more violations, then asynchronous reset in EW green
      for (int k = 0; k < 3; k++) begin
         step(G, R, 0);
         step(3'b111, 3'b111, 0);
         check("t6_viol_pulse", err_pulse, 1);
      end
`ifdef TRAFFIC_MON_ERR_COUNT_EN
      check("t6_err_count", err_count, 3);
`endif
      for (int i = 0; i < 9; i++) step(ns_tab[i], ew_tab[i], 0);
      check("t6_mid_ewg", phase, 4);
      check("t6_pre_cycles", cycle_count, 3);
      #2 rstn = 1'b0;
      #1;
      check("t6_rst_phase", phase, 0);
      check("t6_rst_synced", synced, 0);
      check("t6_rst_code", err_code, 0);
      check("t6_rst_sticky", err_sticky, 0);
      check("t6_rst_pulse", err_pulse, 0);
      check("t6_rst_cycles", cycle_count, 0);
`ifdef TRAFFIC_MON_ERR_COUNT_EN
      check("t6_rst_err_count", err_count, 0);
`endif
      @(negedge clk);
      rstn = 1'b1;
      step(G, R, 0);
      check("t6_resync", synced, 1);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
